key_event_detect: RTL and testbench
===================================

Name: key_event_detect

Overview:
- Per-button front end for the key-driven mode FSM.
- Synchronises one raw push-button input and debounces it.
- Classifies each press as short click or long press, and emits single-cycle event pulses plus a clean level.
- One instance per board button; the mode-control FSM consumes its pulses (press_pulse_o or short_click_o / long_press_o).

Parameters:
- DELAY_TIME, 20'd1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range 1..2^20-1.
- LONG_TIME, 28'd50_000_000: cycles from accepted press to long-press event (1 s at 50 MHz); legal range 2..2^28-1.

Ports:
- sys_clk_i  input  1  system clock.
- sys_rst_n_i  input  1  asynchronous, active-low reset.
- key_button_i  input  1  raw button, active-low (0 = pressed), asynchronous to clock.
- key_value_o  output  1  debounced level, 1 = released.
- press_pulse_o  output  1  one-cycle pulse on accepted press (debounced 1->0).
- release_pulse_o  output  1  one-cycle pulse on accepted release (debounced 0->1).
- short_click_o  output  1  one-cycle pulse on release when the hold was shorter than LONG_TIME.
- long_press_o  output  1  one-cycle pulse when the hold reaches LONG_TIME; at most once per press.
- hold_o  output  1  level, high while in LONG_HELD.

Behaviour:
- Clock and reset: sys_clk_i clocks all logic; reset sys_rst_n_i is asynchronous, active-low.
- Reset values:
  - key_value_o = 1; all pulse outputs = 0; hold_o = 0.
  - Both synchroniser flops = 1; debounce counter = 0; hold counter = 0; state = RELEASED.
- Synchroniser: two-flop chain on key_button_i. The second flop output is sync_key; no other logic samples the raw input.
- Debounce counter:
  - Counter dcnt (20 bit). If sync_key == key_value_o, dcnt <= 0.
  - Otherwise, if dcnt == DELAY_TIME-1: key_value_o <= sync_key and dcnt <= 0; else dcnt <= dcnt+1.
  - A level change is accepted after exactly DELAY_TIME consecutive differing cycles. Any bounce back clears dcnt.
  - Latency from a clean raw edge to key_value_o change: 2 + DELAY_TIME clocks.
- Pulse timing:
  - press_pulse_o / release_pulse_o are registered with key_value_o.
  - Each is high only in the first cycle key_value_o shows its new value.
- State machine (one-hot, 3 states):
  - RELEASED:
    - On accepted press -> PRESSED; hcnt <= 0.
  - PRESSED:
    - hcnt increments each cycle.
    - If hcnt == LONG_TIME-1 -> LONG_HELD, with long_press_o asserted in the cycle LONG_HELD is entered. This is exactly LONG_TIME cycles after the press_pulse_o cycle.
    - Else, on accepted release -> RELEASED, with short_click_o asserted in the same cycle as release_pulse_o.
  - LONG_HELD:
    - hold_o = 1; hcnt frozen.
    - On accepted release -> RELEASED, with release_pulse_o only; no short_click_o.
  - Illegal state encoding -> RELEASED next cycle; no pulses.
- Simultaneous events:
  - Release accepted in the same cycle the long threshold is reached: long_press_o and release_pulse_o both pulse, short_click_o stays 0, next state RELEASED.
  - short_click_o and long_press_o are never high together. At most one of them per press.
- Glitches shorter than DELAY_TIME cycles produce no output change.
- Reset mid-press: everything returns to reset values.
  - If the button is still held after reset, it is debounced afresh. A new press_pulse_o follows 2 + DELAY_TIME clocks after reset release.
- Counter widths are fixed (20 / 28 bit); no wrap can occur within legal parameter ranges.

Test Plan:
All scenarios use DELAY_TIME=4, LONG_TIME=20.
1. Reset then idle high input for 50 cycles -> key_value_o=1, all pulses 0, hold_o=0 throughout.
2. Raw low pulse of 3 cycles, then high -> no change on key_value_o; no pulses. Repeat with 4-cycle low -> press_pulse_o at raw-edge+6, then release_pulse_o and short_click_o at raw-rise+6.
3. Bouncy press (alternating 1-cycle levels for 10 cycles, then steady low) -> exactly one press_pulse_o, 6 cycles after steady low begins.
4. Hold low 40 cycles after press accept -> long_press_o exactly 20 cycles after press_pulse_o, hold_o high until release accept. On release: release_pulse_o only, short_click_o never asserted.
5. Release timed so the release accept lands exactly 20 cycles after press_pulse_o -> long_press_o and release_pulse_o in the same cycle, short_click_o=0, state RELEASED.
6. Assert reset 10 cycles into a long hold with the button kept low -> outputs immediately at reset values. After deassert: press_pulse_o at +6 cycles, long_press_o 20 cycles later.

Source files
------------

// File: rtl/key_event_detect_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_detect_if
// Description : Button input and event outputs of one key_event_detect.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_detect_if;
    logic key_button_i;
    logic key_value_o;
    logic press_pulse_o;
    logic release_pulse_o;
    logic short_click_o;
    logic long_press_o;
    logic hold_o;

    // The detector produces the events; the consumer drives the raw button.
    modport master (
        input  key_button_i,
        output key_value_o,
        output press_pulse_o,
        output release_pulse_o,
        output short_click_o,
        output long_press_o,
        output hold_o
    );

    modport slave (
        output key_button_i,
        input  key_value_o,
        input  press_pulse_o,
        input  release_pulse_o,
        input  short_click_o,
        input  long_press_o,
        input  hold_o
    );
endinterface
`default_nettype wire

// File: rtl/key_event_detect.sv
`default_nettype none
// ============================================================================
// Module      : key_event_detect
// Description : Synchronise, debounce and classify one active-low push button.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_detect #(
    parameter logic [19:0] DELAY_TIME = 20'd1_000_000,
    parameter logic [27:0] LONG_TIME  = 28'd50_000_000
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_n_i,
    key_event_detect_if.master key_if
);

    typedef enum logic [2:0] {
        ST_RELEASED  = 3'b001,
        ST_PRESSED   = 3'b010,
        ST_LONG_HELD = 3'b100
    } state_t;

    localparam logic [19:0] c_delay_last = DELAY_TIME - 20'd1;
    localparam logic [27:0] c_long_last  = LONG_TIME - 28'd1;

    logic        r_sync_1;
    logic        r_sync_2;
    logic [19:0] r_dcnt;
    logic        r_key_value;
    logic        r_press_pulse;
    logic        r_release_pulse;
    logic [27:0] r_hcnt;
    state_t      r_state;
    logic        r_short_click;
    logic        r_long_press;
    logic        r_hold;

    logic        w_differs;
    logic        w_accept;
    logic        w_press_acc;
    logic        w_release_acc;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
        end else begin
            r_sync_1 <= key_if.key_button_i;
            r_sync_2 <= r_sync_1;
        end
    end

    // A change is accepted on the DELAY_TIME-th consecutive differing sample.
    assign w_differs     = (r_sync_2 != r_key_value);
    assign w_accept      = w_differs && (r_dcnt == c_delay_last);
    assign w_press_acc   = w_accept && !r_sync_2;
    assign w_release_acc = w_accept &&  r_sync_2;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_dcnt          <= 20'd0;
            r_key_value     <= 1'b1;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= w_press_acc;
            r_release_pulse <= w_release_acc;
            if (!w_differs) begin
                r_dcnt <= 20'd0;
            end else if (w_accept) begin
                r_key_value <= r_sync_2;
                r_dcnt      <= 20'd0;
            end else begin
                r_dcnt <= r_dcnt + 20'd1;
            end
        end
    end

    // Hold classifier; outputs registered so they align with the debounced pulses.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state       <= ST_RELEASED;
            r_hcnt        <= 28'd0;
            r_short_click <= 1'b0;
            r_long_press  <= 1'b0;
            r_hold        <= 1'b0;
        end else begin
            r_short_click <= 1'b0;
            r_long_press  <= 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    r_hold <= 1'b0;
                    if (w_press_acc) begin
                        r_state <= ST_PRESSED;
                        r_hcnt  <= 28'd0;
                    end
                end
                ST_PRESSED: begin
                    r_hcnt <= r_hcnt + 28'd1;
                    r_hold <= 1'b0;
                    if (r_hcnt == c_long_last) begin
                        // Threshold wins over a coincident release: no short click.
                        r_long_press <= 1'b1;
                        if (w_release_acc) begin
                            r_state <= ST_RELEASED;
                        end else begin
                            r_state <= ST_LONG_HELD;
                            r_hold  <= 1'b1;
                        end
                    end else if (w_release_acc) begin
                        r_short_click <= 1'b1;
                        r_state       <= ST_RELEASED;
                    end
                end
                ST_LONG_HELD: begin
                    if (w_release_acc) begin
                        r_state <= ST_RELEASED;
                        r_hold  <= 1'b0;
                    end else begin
                        r_hold <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RELEASED;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign key_if.key_value_o     = r_key_value;
    assign key_if.press_pulse_o   = r_press_pulse;
    assign key_if.release_pulse_o = r_release_pulse;
    assign key_if.short_click_o   = r_short_click;
    assign key_if.long_press_o    = r_long_press;
    assign key_if.hold_o          = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_key_event_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_detect
// Description : Directed and random stimulus against a timestamp-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_detect;

    localparam int c_delay = 4;
    localparam int c_long  = 20;

    logic sys_clk_i;
    logic sys_rst_n_i;

    key_event_detect_if u_if ();

    key_event_detect #(
        .DELAY_TIME (20'(c_delay)),
        .LONG_TIME  (28'(c_long))
    ) u_dut (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .key_if      (u_if.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: raw samples pass through two sample delays, then a run-length
    // rule; press/long/release decisions are made from edge timestamps.
    bit m_dly_a, m_dly_b;
    bit m_level;
    int m_run;
    int m_edge;
    int m_press_edge;
    bit m_pressed, m_long_done;
    bit e_press, e_release, e_short, e_long;

    initial begin
        sys_clk_i = 1'b0;
        forever #5 sys_clk_i = ~sys_clk_i;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dly_a     = 1'b1;
        m_dly_b     = 1'b1;
        m_level     = 1'b1;
        m_run       = 0;
        m_edge      = 0;
        m_pressed   = 1'b0;
        m_long_done = 1'b0;
        e_press = 0; e_release = 0; e_short = 0; e_long = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit seen;
        m_edge++;
        seen    = m_dly_b;
        m_dly_b = m_dly_a;
        m_dly_a = raw;
        e_press = 0; e_release = 0; e_short = 0; e_long = 0;

        if (m_pressed && !m_long_done && (m_edge == m_press_edge + c_long)) begin
            e_long      = 1;
            m_long_done = 1;
        end

        if (seen != m_level) begin
            m_run++;
            if (m_run == c_delay) begin
                m_level = seen;
                m_run   = 0;
                if (!seen) begin
                    e_press      = 1;
                    m_pressed    = 1;
                    m_long_done  = 0;
                    m_press_edge = m_edge;
                end else begin
                    e_release = 1;
                    e_short   = m_pressed && !m_long_done;
                    m_pressed = 0;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_all();
        check("key_value",     u_if.key_value_o,     m_level);
        check("press_pulse",   u_if.press_pulse_o,   e_press);
        check("release_pulse", u_if.release_pulse_o, e_release);
        check("short_click",   u_if.short_click_o,   e_short);
        check("long_press",    u_if.long_press_o,    e_long);
        check("hold",          u_if.hold_o,          m_pressed && m_long_done);
        check("short_long_excl", u_if.short_click_o && u_if.long_press_o, 1'b0);
    endtask

    task automatic step(input bit raw);
        @(negedge sys_clk_i);
        u_if.key_button_i = raw;
        @(posedge sys_clk_i);
        model_edge(raw);
        #1;
        check_all();
    endtask

    task automatic run_level(input bit raw, input int cycles);
        for (int i = 0; i < cycles; i++) step(raw);
    endtask

    // Reset is asserted asynchronously mid-cycle; released just after a
    // rising edge so every later edge is one the model steps through.
    task automatic apply_reset();
        @(negedge sys_clk_i);
        #1;
        sys_rst_n_i = 1'b0;
        #1;
        model_reset();
        check("rst_key_value",     u_if.key_value_o,     1'b1);
        check("rst_press_pulse",   u_if.press_pulse_o,   1'b0);
        check("rst_release_pulse", u_if.release_pulse_o, 1'b0);
        check("rst_short_click",   u_if.short_click_o,   1'b0);
        check("rst_long_press",    u_if.long_press_o,    1'b0);
        check("rst_hold",          u_if.hold_o,          1'b0);
        repeat (3) @(posedge sys_clk_i);
        #2;
        sys_rst_n_i = 1'b1;
    endtask

    initial begin
        int len;
        bit lvl;
        u_if.key_button_i = 1'b1;
        sys_rst_n_i       = 1'b0;
        model_reset();

        apply_reset();
        run_level(1'b1, 50);

        // Glitch shorter than the debounce window, then one just long enough.
        run_level(1'b0, 3);
        run_level(1'b1, 20);
        run_level(1'b0, 4);
        run_level(1'b1, 20);

        // Bouncy press settling low, then a short release.
        for (int i = 0; i < 10; i++) step(i[0]);
        run_level(1'b0, 15);
        run_level(1'b1, 15);

        // Long hold.
        run_level(1'b0, 6 + 40);
        run_level(1'b1, 20);

        // Release accepted on the very edge the long threshold is reached.
        run_level(1'b0, 20);
        run_level(1'b1, 20);

        // Reset in the middle of a long hold with the button kept down.
        run_level(1'b0, 6 + 10);
        apply_reset();
        run_level(1'b0, 40);
        run_level(1'b1, 20);

        // Random bouncing and holds of assorted lengths.
        lvl = 1'b1;
        for (int seg = 0; seg < 80; seg++) begin
            lvl = ~lvl;
            if ($urandom_range(0, 2) == 0)
                len = $urandom_range(10, 45);
            else
                len = $urandom_range(1, 6);
            run_level(lvl, len);
        end
        run_level(1'b1, 30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
